sram_req_arbiter: RTL and testbench
===================================

Name: sram_req_arbiter

Overview:
Shares one request/response memory port between the instruction-fetch requester (read-only) and the load/store requester (read/write) of the 5-stage pipeline.
- Arbitrates by fixed data priority with an anti-starvation override.
- Holds a grant until the downstream accepts it.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response back to its originator.
- Sits between the pipeline stages and the unified memory/bus bridge.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_OUTSTANDING, 2, ID FIFO depth (accepted but unanswered transactions), power of 2, ≥1
STARVE_LIMIT, 4, consecutive contended data grants before inst wins one arbitration (≥1)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  reset, asynchronous, active-low
inst_req  in  1  fetch request valid
inst_addr  in  ADDR_W  fetch address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch response valid this cycle
data_req  in  1  load/store request valid
data_wr  in  1  1=store, 0=load
data_wstrb  in  DATA_W/8  byte enables (store)
data_addr  in  ADDR_W  load/store address
data_wdata  in  DATA_W  store data
data_addr_ok  out  1  load/store request accepted this cycle
data_data_ok  out  1  load/store response valid this cycle
rdata  out  DATA_W  response data, shared by both requesters
ram_req  out  1  downstream request valid
ram_wr  out  1  downstream write
ram_wstrb  out  DATA_W/8  downstream byte enables
ram_addr  out  ADDR_W  downstream address
ram_wdata  out  DATA_W  downstream write data
ram_addr_ok  in  1  downstream accepts request
ram_data_ok  in  1  downstream response valid (in order)
ram_rdata  in  DATA_W  downstream response data
err_resp  out  1  sticky: response arrived with no outstanding transaction

Behaviour:
- While resetn=0, all outputs are forced to 0 asynchronously. Reset clears: FIFO to empty (count 0), grant state to IDLE, starvation counter to 0, err_resp to 0.
- Grant FSM:
  - IDLE: select a requester combinationally. If the FIFO is full (registered count == MAX_OUTSTANDING), select none.
    - Only one requester active: grant it.
    - Both active: grant data, unless starve_cnt == STARVE_LIMIT, in which case grant inst.
  - A grant with ram_addr_ok=0 moves the FSM to HOLD_I or HOLD_D.
  - HOLD_x: the granted requester's fields drive ram_* unchanged; no re-arbitration. Return to IDLE on acceptance (ram_req & ram_addr_ok).
  - HOLD_x with its requester's req dropped is illegal. The arbiter drops ram_req and returns to IDLE.
- ram_* mux: selected requester's fields. An inst grant drives ram_wr=0 and ram_wstrb=0. With no grant, all ram_* = 0.
- addr_ok: x_addr_ok = ram_addr_ok & ram_req & (grant==x). Zero-cycle latency from ram_addr_ok.
- Acceptance pushes a 1-bit ID (0=inst, 1=data) into the FIFO.
- Response path:
  - ram_data_ok with FIFO non-empty pops the head.
  - Head ID selects inst_data_ok or data_data_ok (exactly one, same cycle).
  - rdata = ram_rdata, combinational.
- Full boundary: push is blocked while the registered count is full, even if a pop occurs the same cycle. This avoids a combinational path from ram_data_ok to ram_req; the slot is usable the next cycle.
- Simultaneous push and pop when not full: count is unchanged; pointers wrap modulo MAX_OUTSTANDING.
- ram_data_ok with FIFO empty: ignored (no data_ok pulses). err_resp is set to 1 and stays set until reset.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when a data request is accepted while inst_req=1.
  - Clears when an inst request is accepted.
  - Unchanged otherwise.
- Reset mid-operation: outstanding IDs are discarded. Any late response after release triggers err_resp.

Test Plan:
1. Inst-only: inst_req=1, inst_addr=0x1C000000, ram_addr_ok=1 at cycle 0 -> ram_addr=0x1C000000, ram_wr=0, inst_addr_ok=1 at cycle 0. Then ram_data_ok=1 at cycle 2 with ram_rdata=0x02800421 -> inst_data_ok=1, data_data_ok=0, rdata=0x02800421.
2. Contention: both requesting at cycle 0 (data store, addr 0x1C008000, wstrb 0xF, wdata 0x12345678), ram_addr_ok=1 -> data accepted at cycle 0, inst accepted at cycle 1. Responses at cycles 3 and 4 -> data_data_ok at cycle 3, inst_data_ok at cycle 4.
3. Hold: data_req with ram_addr_ok=0 for 3 cycles while inst_req=1 -> ram_addr stays the data address and inst_addr_ok=0 throughout. Cycle 3 ram_addr_ok=1 -> data_addr_ok=1.
4. Full (MAX_OUTSTANDING=2): two accepts with no responses -> ram_req=0 at the third request. ram_data_ok at cycle N -> ram_req=0 at cycle N, 1 at cycle N+1.
5. Starvation (STARVE_LIMIT=4): both requesting continuously, ram_addr_ok=1, responses immediate -> grants D,D,D,D,I,D,D,D,D,I.
6. Reset mid-flight: one outstanding, pulse resetn=0 -> all outputs 0 immediately. Then ram_data_ok=1 after release -> no data_ok pulse, err_resp=1 and stays 1.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// Two-master arbiter in front of one request/response memory port: fetch (read-only) and load/store.
// Fixed data priority with a starvation override, grant hold until accepted, in-order ID FIFO for response routing.
module sram_req_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   rdata,
  output logic                ram_req,
  output logic                ram_wr,
  output logic [DATA_W/8-1:0] ram_wstrb,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic                ram_addr_ok,
  input  logic                ram_data_ok,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                err_resp
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SC_W   = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

  state_t                     state_q, state_d;
  logic [MAX_OUTSTANDING-1:0] id_q;
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           count_q;
  logic [SC_W-1:0]            starve_q;

  logic req_i, req_d, full, empty;
  logic grant_i, grant_d, accept, push, pop;

  // Requests are masked by reset so every combinational output is forced low while resetn=0.
  assign req_i = resetn & inst_req;
  assign req_d = resetn & data_req;
  assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Grant selection and next state; HOLD keeps the winner until acceptance or illegal drop.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!full) begin
          if (req_d && (!req_i || starve_q != SC_W'(STARVE_LIMIT))) grant_d = 1'b1;
          else if (req_i)                                            grant_i = 1'b1;
        end
      end
      HOLD_I:  grant_i = req_i;
      HOLD_D:  grant_d = req_d;
      default: ;
    endcase
    if (grant_i && !ram_addr_ok)      state_d = HOLD_I;
    else if (grant_d && !ram_addr_ok) state_d = HOLD_D;
    else                              state_d = IDLE;
  end

  always_comb begin
    ram_req   = grant_i | grant_d;
    ram_wr    = 1'b0;
    ram_wstrb = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant_d) begin
      ram_wr    = data_wr;
      ram_wstrb = data_wstrb;
      ram_addr  = data_addr;
      ram_wdata = data_wdata;
    end else if (grant_i) begin
      ram_addr  = inst_addr;
    end
  end

  assign accept       = ram_req & ram_addr_ok;
  assign inst_addr_ok = accept & grant_i;
  assign data_addr_ok = accept & grant_d;

  // Push can never coincide with a registered-full FIFO because full blocks any grant.
  assign push = accept;
  assign pop  = resetn & ram_data_ok & ~empty;

  assign inst_data_ok = pop & ~id_q[rd_ptr_q];
  assign data_data_ok = pop &  id_q[rd_ptr_q];
  assign rdata        = resetn ? ram_rdata : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        id_q[wr_ptr_q] <= grant_d;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  // Contended data wins count toward forcing one fetch grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
    end else if (inst_addr_ok) begin
      starve_q <= '0;
    end else if (data_addr_ok && inst_req && starve_q != SC_W'(STARVE_LIMIT)) begin
      starve_q <= starve_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                   err_resp <= 1'b0;
    else if (ram_data_ok && empty) err_resp <= 1'b1;
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: inputs driven at negedge, outputs checked 1ns later.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] rdata;
  logic        ram_req, ram_wr;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_addr, ram_wdata;
  logic        ram_addr_ok, ram_data_ok;
  logic [31:0] ram_rdata;
  logic        err_resp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .rdata(rdata),
    .ram_req(ram_req), .ram_wr(ram_wr), .ram_wstrb(ram_wstrb),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_addr_ok(ram_addr_ok), .ram_data_ok(ram_data_ok), .ram_rdata(ram_rdata),
    .err_resp(err_resp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wr = 0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    ram_addr_ok = 0; ram_data_ok = 0; ram_rdata = '0;
  endtask

  logic [9:0] exp_d;

  initial begin
    exp_d = 10'b01111_01111;  // bit k = expected data grant in starvation run (LSB first)

    // Reset with live requests: outputs must stay low
    resetn = 0;
    idle_inputs();
    inst_req = 1; inst_addr = 32'h1C00_0000; ram_addr_ok = 1; ram_rdata = 32'hFFFF_0000;
    #1;
    chk("rst_ram_req", 64'(ram_req), 64'd0);
    chk("rst_inst_addr_ok", 64'(inst_addr_ok), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_err", 64'(err_resp), 64'd0);
    @(negedge clk); @(negedge clk);
    resetn = 1; idle_inputs();

    // 1: inst only
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1C00_0000; ram_addr_ok = 1; #1;
    chk("t1_ram_req", 64'(ram_req), 64'd1);
    chk("t1_ram_addr", 64'(ram_addr), 64'h1C00_0000);
    chk("t1_ram_wr", 64'(ram_wr), 64'd0);
    chk("t1_inst_addr_ok", 64'(inst_addr_ok), 64'd1);
    chk("t1_data_addr_ok", 64'(data_addr_ok), 64'd0);
    @(negedge clk);
    idle_inputs(); #1;
    chk("t1_ram_req_idle", 64'(ram_req), 64'd0);
    @(negedge clk);
    ram_data_ok = 1; ram_rdata = 32'h0280_0421; #1;
    chk("t1_inst_data_ok", 64'(inst_data_ok), 64'd1);
    chk("t1_data_data_ok", 64'(data_data_ok), 64'd0);
    chk("t1_rdata", 64'(rdata), 64'h0280_0421);
    @(negedge clk);
    idle_inputs();

    // 2: contention, data first
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1C00_0004;
    data_req = 1; data_wr = 1; data_addr = 32'h1C00_8000; data_wstrb = 4'hF; data_wdata = 32'h1234_5678;
    ram_addr_ok = 1; #1;
    chk("t2_data_addr_ok", 64'(data_addr_ok), 64'd1);
    chk("t2_inst_addr_ok0", 64'(inst_addr_ok), 64'd0);
    chk("t2_ram_wr", 64'(ram_wr), 64'd1);
    chk("t2_ram_addr_d", 64'(ram_addr), 64'h1C00_8000);
    chk("t2_ram_wdata", 64'(ram_wdata), 64'h1234_5678);
    chk("t2_ram_wstrb", 64'(ram_wstrb), 64'hF);
    @(negedge clk);
    data_req = 0; #1;
    chk("t2_inst_addr_ok1", 64'(inst_addr_ok), 64'd1);
    chk("t2_ram_addr_i", 64'(ram_addr), 64'h1C00_0004);
    chk("t2_ram_wr_i", 64'(ram_wr), 64'd0);
    chk("t2_ram_wstrb_i", 64'(ram_wstrb), 64'h0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    ram_data_ok = 1; ram_rdata = 32'hAAAA_5555; #1;
    chk("t2_rsp0_data", 64'(data_data_ok), 64'd1);
    chk("t2_rsp0_inst", 64'(inst_data_ok), 64'd0);
    @(negedge clk);
    ram_rdata = 32'h5555_AAAA; #1;
    chk("t2_rsp1_inst", 64'(inst_data_ok), 64'd1);
    chk("t2_rsp1_data", 64'(data_data_ok), 64'd0);
    chk("t2_rsp1_rdata", 64'(rdata), 64'h5555_AAAA);
    @(negedge clk);
    idle_inputs();

    // 3: hold data grant while downstream stalls
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      inst_req = 1; inst_addr = 32'h1C00_0008;
      data_req = 1; data_wr = 0; data_addr = 32'h1C00_1000; ram_addr_ok = 0; #1;
      chk("t3_hold_addr", 64'(ram_addr), 64'h1C00_1000);
      chk("t3_hold_inst_ok", 64'(inst_addr_ok), 64'd0);
    end
    @(negedge clk);
    ram_addr_ok = 1; #1;
    chk("t3_data_addr_ok", 64'(data_addr_ok), 64'd1);
    chk("t3_accept_addr", 64'(ram_addr), 64'h1C00_1000);
    @(negedge clk);
    data_req = 0; #1;
    chk("t3_inst_after", 64'(inst_addr_ok), 64'd1);
    @(negedge clk);
    idle_inputs(); ram_data_ok = 1; #1;
    chk("t3_rsp_data", 64'(data_data_ok), 64'd1);
    @(negedge clk);
    #1;
    chk("t3_rsp_inst", 64'(inst_data_ok), 64'd1);
    @(negedge clk);
    idle_inputs();

    // 4: FIFO full boundary
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1C00_0010; ram_addr_ok = 1; #1;
    chk("t4_acc0", 64'(inst_addr_ok), 64'd1);
    @(negedge clk); #1;
    chk("t4_acc1", 64'(inst_addr_ok), 64'd1);
    @(negedge clk); #1;
    chk("t4_full_req", 64'(ram_req), 64'd0);
    chk("t4_full_ok", 64'(inst_addr_ok), 64'd0);
    @(negedge clk);
    ram_data_ok = 1; #1;
    chk("t4_pop_req_same", 64'(ram_req), 64'd0);
    chk("t4_pop_inst_ok", 64'(inst_data_ok), 64'd1);
    @(negedge clk);
    ram_data_ok = 0; #1;
    chk("t4_req_next", 64'(ram_req), 64'd1);
    chk("t4_acc_next", 64'(inst_addr_ok), 64'd1);
    @(negedge clk);
    idle_inputs(); ram_data_ok = 1;
    @(negedge clk);
    @(negedge clk);
    idle_inputs(); #1;
    chk("t4_drained_err", 64'(err_resp), 64'd0);

    // 5: starvation override pattern D,D,D,D,I,D,D,D,D,I
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      inst_req = 1; inst_addr = 32'h1C00_0020;
      data_req = 1; data_wr = 0; data_addr = 32'h1C00_2000;
      ram_addr_ok = 1; ram_data_ok = (k > 0); #1;
      chk($sformatf("t5_grant_d%0d", k), 64'(data_addr_ok), 64'(exp_d[k]));
      chk($sformatf("t5_grant_i%0d", k), 64'(inst_addr_ok), 64'(!exp_d[k]));
      if (k > 0) chk($sformatf("t5_rsp_d%0d", k), 64'(data_data_ok), 64'(exp_d[k-1]));
    end
    @(negedge clk);
    idle_inputs(); ram_data_ok = 1; #1;
    chk("t5_last_rsp", 64'(inst_data_ok), 64'd1);
    @(negedge clk);
    idle_inputs();

    // 6: reset mid-flight, late response flags err_resp
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1C00_0030; ram_addr_ok = 1; #1;
    chk("t6_acc", 64'(inst_addr_ok), 64'd1);
    @(negedge clk);
    ram_rdata = 32'hCAFE_F00D; #1;
    resetn = 0; #1;
    chk("t6_rst_req", 64'(ram_req), 64'd0);
    chk("t6_rst_ok", 64'(inst_addr_ok), 64'd0);
    chk("t6_rst_addr", 64'(ram_addr), 64'd0);
    chk("t6_rst_rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    resetn = 1; idle_inputs(); ram_data_ok = 1; ram_rdata = 32'hDEAD_BEEF; #1;
    chk("t6_late_inst", 64'(inst_data_ok), 64'd0);
    chk("t6_late_data", 64'(data_data_ok), 64'd0);
    chk("t6_err_before", 64'(err_resp), 64'd0);
    @(negedge clk);
    idle_inputs(); #1;
    chk("t6_err_set", 64'(err_resp), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      inst_req = 1; ram_addr_ok = 1; ram_data_ok = (c == 1); #1;
      chk("t6_err_sticky", 64'(err_resp), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
